// File: rtl/mesh_scheduler.sv
// mesh_scheduler: sequences one K-vector matmul job through the systolic mesh (pump gating, skewed row ctrl, result handshake).
// Defining MESH_SCHED_ABORT_EN adds abort_i, which cancels a running job without a done_o pulse.
module mesh_scheduler #(
  parameter int MESH_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_valid_i,
  output logic                  start_ready_o,
  input  logic [CNT_WIDTH-1:0]  k_len_i,
  input  logic                  acc_init_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
`ifdef MESH_SCHED_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic                  pump_o,
  output logic [MESH_WIDTH-1:0] row_valid_o,
  output logic [MESH_WIDTH-1:0] row_first_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int LAT  = 2 * MESH_WIDTH - 1;
  localparam int IF_W = $clog2(LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] k_q, k_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 init_q, init_d;
  logic [IF_W-1:0]      inflight_q, inflight_d;
  logic [LAT-1:0]       vld_q, vld_d;
  logic [LAT-1:0]       first_q, first_d;
  logic [LAT-1:0]       last_q, last_d;

  logic stall, abort, accept, tail_out, first_in, last_in;

`ifdef MESH_SCHED_ABORT_EN
  assign abort = abort_i & (state_q != S_IDLE);
`else
  assign abort = 1'b0;
`endif

  // A pending result that the consumer refuses freezes the whole mesh.
  assign stall         = vld_q[LAT-1] & ~out_ready_i;
  assign start_ready_o = (state_q == S_IDLE);
  assign in_ready_o    = (state_q == S_FEED) & ~stall & ~abort;

  always_comb begin
    pump_o = 1'b0;
    if (state_q == S_FEED) begin
      pump_o = in_valid_i & in_ready_o;
    end else if (state_q == S_DRAIN) begin
      pump_o = ~stall & (inflight_q != '0) & ~abort;
    end
  end

  assign accept   = (state_q == S_FEED) & pump_o;
  assign tail_out = pump_o & vld_q[LAT-1];
  assign first_in = init_q & (cnt_q == '0);
  assign last_in  = (cnt_q == (k_q - CNT_WIDTH'(1)));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    init_d     = init_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q + IF_W'(accept) - IF_W'(tail_out);
    vld_d      = vld_q;
    first_d    = first_q;
    last_d     = last_q;

    if (pump_o) begin
      vld_d   = {vld_q[LAT-2:0], accept};
      first_d = {first_q[LAT-2:0], accept & first_in};
      last_d  = {last_q[LAT-2:0], accept & last_in};
    end
    if (accept) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_valid_i) begin
          k_d     = k_len_i;
          init_d  = acc_init_i;
          cnt_d   = '0;
          state_d = (k_len_i != '0) ? S_FEED : S_DONE;
        end
      end
      S_FEED:  if (accept & last_in) state_d = S_DRAIN;
      // Leave on the pump that retires the last result, not a cycle later.
      S_DRAIN: if (inflight_d == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      inflight_d = '0;
      vld_d      = '0;
      first_d    = '0;
      last_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      init_q     <= 1'b0;
      cnt_q      <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
      first_q    <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      init_q     <= init_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  assign row_valid_o = vld_q[MESH_WIDTH-1:0];
  assign row_first_o = first_q[MESH_WIDTH-1:0];
  assign out_valid_o = vld_q[LAT-1];
  assign out_last_o  = last_q[LAT-1];
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_mesh_scheduler.sv
// Bench for mesh_scheduler: a job-level model (list of in-flight vectors and their pump ages) checked every cycle,
// plus directed scenarios with hand-computed totals.
module tb_mesh_scheduler;
  localparam int MW  = 4;
  localparam int CW  = 8;
  localparam int LAT = 2 * MW - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_valid_i = 1'b0;
  logic          start_ready_o;
  logic [CW-1:0] k_len_i = '0;
  logic          acc_init_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          abort_i = 1'b0;
  logic          pump_o;
  logic [MW-1:0] row_valid_o;
  logic [MW-1:0] row_first_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  mesh_scheduler #(.MESH_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_valid_i (start_valid_i),
    .start_ready_o (start_ready_o),
    .k_len_i       (k_len_i),
    .acc_init_i    (acc_init_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
`ifdef MESH_SCHED_ABORT_EN
    .abort_i       (abort_i),
`endif
    .pump_o        (pump_o),
    .row_valid_o   (row_valid_o),
    .row_first_o   (row_first_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_last_o    (out_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // Model: each accepted vector carries its index and the number of pumps since acceptance.
  typedef struct { int age; int idx; } vec_t;
  vec_t m_vecs[$];
  bit   m_active, m_done_pend, m_init;
  int   m_k, m_acc;

  int checks = 0, errors = 0, cyc = 0;
  int n_pump = 0, n_ov = 0, n_last = 0, n_first = 0, n_done = 0;
  int start_cyc = 0, done_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_vecs.delete();
    m_active = 0; m_done_pend = 0; m_init = 0; m_k = 0; m_acc = 0;
  endtask

  task automatic model_step();
    bit idle, feeding, draining, tail, tail_last, stall, abt, e_inr, e_pump;
    logic [MW-1:0] e_rv, e_rf;
    idle = !m_active && !m_done_pend;
    tail = 0; tail_last = 0; e_rv = '0; e_rf = '0;
    foreach (m_vecs[j]) begin
      if (m_vecs[j].age == LAT - 1) begin
        tail = 1;
        tail_last = (m_vecs[j].idx == m_k - 1);
      end
      if (m_vecs[j].age < MW) begin
        e_rv[m_vecs[j].age] = 1'b1;
        if (m_init && m_vecs[j].idx == 0) e_rf[m_vecs[j].age] = 1'b1;
      end
    end
    feeding  = m_active && (m_acc < m_k);
    draining = m_active && (m_acc == m_k);
    abt      = abort_i && !idle;
    stall    = tail && !out_ready_i;
    e_inr    = feeding && !stall && !abt;
    e_pump   = feeding ? (e_inr && in_valid_i) : (draining && !stall && !abt);

    chk("start_ready", start_ready_o, idle);
    chk("in_ready", in_ready_o, e_inr);
    chk("pump", pump_o, e_pump);
    chk("row_valid", row_valid_o, e_rv);
    chk("row_first", row_first_o, e_rf);
    chk("out_valid", out_valid_o, tail);
    chk("out_last", out_last_o, tail_last);
    chk("busy", busy_o, !idle);
    chk("done", done_o, m_done_pend);

    if (pump_o) n_pump++;
    if (out_valid_o) n_ov++;
    if (out_last_o) n_last++;
    if (row_first_o != '0) n_first++;
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (start_valid_i && start_ready_o) start_cyc = cyc;
    cyc++;

    if (rst_i || abt) begin
      model_clear();
    end else if (m_done_pend) begin
      m_done_pend = 0;
    end else if (idle) begin
      if (start_valid_i) begin
        if (k_len_i == '0) m_done_pend = 1;
        else begin
          m_active = 1; m_k = int'(k_len_i); m_init = acc_init_i; m_acc = 0;
        end
      end
    end else if (e_pump) begin
      if (tail) void'(m_vecs.pop_front());
      foreach (m_vecs[j]) m_vecs[j].age = m_vecs[j].age + 1;
      if (feeding) begin
        m_vecs.push_back('{age: 0, idx: m_acc});
        m_acc++;
      end
      if (m_acc == m_k && m_vecs.size() == 0) begin
        m_active = 0; m_done_pend = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input int k, input bit init);
    int n = 0;
    start_valid_i = 1'b1; k_len_i = CW'(k); acc_init_i = init;
    while (!start_ready_o && n < 200) begin step(); n++; end
    chk("start_timeout", int'(n < 200), 1);
    step();
    start_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 500) begin step(); n++; end
    chk("idle_timeout", int'(n < 500), 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_start_ready", start_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pump", pump_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_last", out_last_o, 0);
    chk("rst_row_valid", row_valid_o, 0);
    chk("rst_row_first", row_first_o, 0);
  endtask

  initial begin
    int p0, ov0, l0, f0, d0, n;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_outputs();
    step();
    rst_i = 1'b0;
    step();

    // K=3, acc_init, free-flowing: 3 feed + 7 drain pumps, done 11 cycles after start.
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    p0 = n_pump; ov0 = n_ov; l0 = n_last; f0 = n_first;
    start_job(3, 1'b1);
    wait_idle();
    chk("k3_pumps", n_pump - p0, 10);
    chk("k3_out_valid_cycles", n_ov - ov0, 3);
    chk("k3_out_last_cycles", n_last - l0, 1);
    chk("k3_first_cycles", n_first - f0, 4);
    chk("k3_done_latency", done_cyc - start_cyc, 11);
    step();

    // K=0: straight to done, no pump.
    p0 = n_pump; d0 = n_done;
    start_job(0, 1'b1);
    wait_idle();
    chk("k0_pumps", n_pump - p0, 0);
    chk("k0_done_latency", done_cyc - start_cyc, 1);
    chk("k0_done_count", n_done - d0, 1);
    chk("k0_start_ready", start_ready_o, 1);

    // K=5 with the consumer refusing the first result for 4 cycles.
    ov0 = n_ov; l0 = n_last;
    start_job(5, 1'b1);
    n = 0;
    while (!out_valid_o && n < 100) begin step(); n++; end
    chk("k5_result_timeout", int'(n < 100), 1);
    out_ready_i = 1'b0;
    p0 = n_pump;
    repeat (4) step();
    chk("k5_hold_pumps", n_pump - p0, 0);
    chk("k5_hold_out_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    wait_idle();
    chk("k5_out_valid_cycles", n_ov - ov0, 9);
    chk("k5_out_last_cycles", n_last - l0, 1);

    // K=4, no accumulator clear, feeder toggling 1,0,1,0.
    p0 = n_pump; f0 = n_first;
    start_job(4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_valid_i = (i % 2 == 0);
      step();
    end
    in_valid_i = 1'b1;
    wait_idle();
    chk("toggle_pumps", n_pump - p0, 11);
    chk("toggle_first_cycles", n_first - f0, 0);

    // Reset in DRAIN with 3 vectors in flight.
    d0 = n_done;
    start_job(3, 1'b1);
    repeat (3) step();
    chk("mid_drain_busy", busy_o, 1);
    chk("mid_drain_in_ready", in_ready_o, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_reset_outputs();
    repeat (10) step();
    chk("rst_no_done", n_done - d0, 0);

`ifdef MESH_SCHED_ABORT_EN
    d0 = n_done;
    start_job(4, 1'b1);
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    ov0 = n_ov;
    repeat (10) step();
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_out_valid", n_ov - ov0, 0);
    chk("abort_idle", busy_o, 0);
    d0 = n_done;
    start_job(1, 1'b1);
    wait_idle();
    chk("after_abort_done", n_done - d0, 1);
`endif

    // Randomized traffic, including start requests while busy.
    for (int i = 0; i < 3000; i++) begin
      start_valid_i = ($urandom % 4 == 0);
      k_len_i       = CW'($urandom % 13);
      acc_init_i    = $urandom % 2;
      in_valid_i    = ($urandom % 10 < 7);
      out_ready_i   = ($urandom % 10 < 7);
      step();
    end
    start_valid_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    wait_idle();
    step();
    chk("final_idle", start_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
